// File: rtl/alsu_op_controller.sv
// Sequences one ALSU operation per command: latch operands, sample the ALSU
// result for one cycle, then hold the response until the consumer takes it.
module alsu_op_controller (
  input  logic       clk,
  input  logic       rst,
  // Command channel. A command transfers on a rising edge where cmd_valid
  // and cmd_ready are both 1; the response transfers likewise on rsp_valid
  // and rsp_ready. A source may not withdraw or change a presented item.
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [5:0] cmd_sel,
  input  logic       cmd_use_acc,
  output logic [3:0] alsu_a,
  output logic [3:0] alsu_b,
  output logic [5:0] alsu_sel,
  input  logic [3:0] alsu_out,
  input  logic       alsu_carry,
  input  logic       alsu_neg,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_neg,
  output logic [7:0] op_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] acc;
  logic       accept;
  logic       capture;
  logic       handshake;

  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The ALSU only ever sees the latched copy, so it stays stable while the
  // command bus is free to change.
  always_ff @(posedge clk) begin
    if (rst) begin
      alsu_a   <= 4'd0;
      alsu_b   <= 4'd0;
      alsu_sel <= 6'd0;
    end else if (accept) begin
      alsu_a   <= cmd_use_acc ? acc : cmd_a;
      alsu_b   <= cmd_b;
      alsu_sel <= cmd_sel;
    end
  end

  // Logic/shift codes (sel[5]) report no carry or sign, whatever the ALSU says.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data  <= 4'd0;
      rsp_carry <= 1'b0;
      rsp_neg   <= 1'b0;
      acc       <= 4'd0;
    end else if (capture) begin
      rsp_data  <= alsu_out;
      acc       <= alsu_out;
      rsp_carry <= alsu_sel[5] ? 1'b0 : alsu_carry;
      rsp_neg   <= alsu_sel[5] ? 1'b0 : alsu_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            op_count <= 8'd0;
    else if (handshake) op_count <= op_count + 8'd1;
  end

endmodule

// File: tb/tb_alsu_op_controller.sv
// Randomized scoreboard bench for alsu_op_controller with a behavioural ALSU
// attached to its operand outputs.
module tb_alsu_op_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic [5:0] cmd_sel = 6'd0;
  logic       cmd_use_acc = 1'b0;
  logic [3:0] alsu_a;
  logic [3:0] alsu_b;
  logic [5:0] alsu_sel;
  logic [3:0] alsu_out;
  logic       alsu_carry;
  logic       alsu_neg;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_neg;
  logic [7:0] op_count;
  logic [1:0] dbg_state;
  logic       force_flags = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [5:0]  exp_q[$];   // {data, carry, neg}
  logic [13:0] op_q[$];    // {a, b, sel}
  int          cyc_q[$];
  logic [3:0]  model_acc = 4'd0;
  logic [7:0]  exp_count = 8'd0;

  alsu_op_controller dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_use_acc(cmd_use_acc),
    .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_sel(alsu_sel),
    .alsu_out(alsu_out), .alsu_carry(alsu_carry), .alsu_neg(alsu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_neg(rsp_neg),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALSU reference ----------------
  // Arithmetic: 0 add, 1 sub (carry = no borrow), 2 increment A, 3 add with carry-in sel[2].
  // Logic:      0 and, 1 or, 2 xor, 3 shift {A,B[0]} left, carry = shifted-out bit.
  function automatic logic [5:0] alsu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [5:0] sel);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    s = 5'd0;
    r = 4'd0;
    c = 1'b0;
    if (!sel[5]) begin
      case (sel[1:0])
        2'd0:    s = {1'b0, a} + {1'b0, b};
        2'd1:    s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        2'd2:    s = {1'b0, a} + 5'd1;
        default: s = {1'b0, a} + {1'b0, b} + {4'd0, sel[2]};
      endcase
      r = s[3:0];
      c = s[4];
    end else begin
      case (sel[1:0])
        2'd0:    r = a & b;
        2'd1:    r = a | b;
        2'd2:    r = a ^ b;
        default: r = {a[2:0], b[0]};
      endcase
      c = a[3];
    end
    return {r, c, r[3]};
  endfunction

  always_comb begin
    {alsu_out, alsu_carry, alsu_neg} = alsu_fn(alsu_a, alsu_b, alsu_sel);
    if (force_flags) begin
      alsu_carry = 1'b1;
      alsu_neg   = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: no DUT response within cycle budget (cycle %0d)", name, cyc);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that took the command.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [5:0] sel,
                       input logic use_acc);
    logic [3:0] a_eff;
    logic [5:0] e;
    bit         ok;
    cmd_valid   = 1'b1;
    cmd_a       = a;
    cmd_b       = b;
    cmd_sel     = sel;
    cmd_use_acc = use_acc;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_ready && !rst) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_fail("cmd_accept");
    else begin
      a_eff = use_acc ? model_acc : a;
      e = alsu_fn(a_eff, b, sel);
      if (force_flags) e[1:0] = 2'b11;
      if (sel[5])      e[1:0] = 2'b00;
      exp_q.push_back(e);
      op_q.push_back({a_eff, b, sel});
      cyc_q.push_back(cyc);
      model_acc = e[5:2];
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(input int delay);
    bit ok;
    rsp_ready = 1'b0;
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_fail("rsp_valid");
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"},  rsp_data, 0);
    check({tag, "_rsp_flags"}, {rsp_carry, rsp_neg}, 0);
    check({tag, "_alsu_ops"},  {alsu_a, alsu_b, alsu_sel}, 0);
    check({tag, "_op_count"},  op_count, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          prev_valid = 0;
  bit          op_check = 0;
  bit          have_ops = 0;
  logic [13:0] held_ops;
  logic [5:0]  held_rsp;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      op_q.delete();
      cyc_q.delete();
      model_acc  = 4'd0;
      exp_count  = 8'd0;
      prev_valid = 0;
      op_check   = 0;
      have_ops   = 0;
    end else begin
      check("ready_valid_excl", {cmd_ready, rsp_valid} == 2'b11, 0);
      check("op_count", op_count, exp_count);
      if (op_check) begin
        if (op_q.size() == 0) bound_fail("op_q_empty");
        else begin
          held_ops = op_q.pop_front();
          have_ops = 1;
        end
        op_check = 0;
      end
      if (have_ops && !cmd_ready) check("alsu_operands", {alsu_a, alsu_b, alsu_sel}, held_ops);
      if (cmd_valid && cmd_ready) op_check = 1;
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0 || cyc_q.size() == 0) bound_fail("unexpected_rsp");
        else begin
          held_rsp = exp_q.pop_front();
          check("rsp_result", {rsp_data, rsp_carry, rsp_neg}, held_rsp);
          check("rsp_latency", cyc - cyc_q.pop_front(), 2);
        end
      end else if (rsp_valid && prev_valid) begin
        check("rsp_hold", {rsp_data, rsp_carry, rsp_neg}, held_rsp);
      end
      if (rsp_valid && rsp_ready) exp_count = exp_count + 8'd1;
      prev_valid = rsp_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("reset");

    // basic: 3 + 5
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(4'h3, 4'h5, 6'h00, 1'b0);
    take_rsp(0);

    // backpressure with ignored command pulses
    issue(4'hA, 4'h7, 6'h01, 1'b0);
    for (int t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      cmd_sel   = 6'($urandom);
      @(negedge clk);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_back_idle", {cmd_ready, rsp_valid}, 2'b10);

    // accumulate: 4 + 5 = 9 then A comes from acc
    @(posedge clk); #1;
    issue(4'h4, 4'h5, 6'h00, 1'b0);
    take_rsp(1);
    issue(4'h0, 4'h1, 6'h00, 1'b1);
    take_rsp(0);

    // flag masking on a logic code, and pass-through on an arithmetic code
    force_flags = 1'b1;
    issue(4'hF, 4'h3, 6'h20, 1'b0);
    take_rsp(2);
    issue(4'h2, 4'h1, 6'h00, 1'b0);
    take_rsp(0);
    force_flags = 1'b0;

    // reset in ISSUE, then in RESP
    rsp_ready = 1'b1;
    issue(4'h6, 4'h6, 6'h00, 1'b0);
    pulse_reset();
    check_reset_vals("rst_issue");
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(4'h7, 4'h2, 6'h02, 1'b0);
    @(posedge clk); #1;
    pulse_reset();
    check_reset_vals("rst_resp");

    // randomized commands with random consumer delay
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      issue(4'($urandom), 4'($urandom), 6'($urandom), 1'($urandom_range(0, 1)));
      take_rsp($urandom_range(0, 3));
    end

    // 256 back-to-back ops from a clean count
    pulse_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 256; k++)
      issue(4'($urandom), 4'($urandom), 6'($urandom), 1'($urandom_range(0, 1)));
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("wrap_op_count", op_count, 0);
    check("drain_exp_q", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
